// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings, arbiter states and bus widths.
package sdram_pkg;
    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int CMD_W  = 4;
    localparam int BUSY_W = 10;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;

    typedef enum logic [2:0] {
        S_INIT,
        S_ARBIT,
        S_AREF,
        S_WRITE,
        S_READ
    } state_t;
endpackage

// File: rtl/sdram_arbit.sv
// Central SDRAM command arbiter: passes init through, then grants refresh > write > read one at a time
// and muxes the granted source onto the pins; a watchdog aborts a grant whose end flag never arrives.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int MAX_BUSY = 1023
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              flag_init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    output logic              ref_en,
    input  logic              flag_ref_end,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              flag_wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              flag_rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              busy_err
);

    // The count starts at 0 on the grant edge, so the last busy cycle sees MAX_BUSY-1.
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MAX_BUSY - 1);

    state_t            state;
    logic [BUSY_W-1:0] busy_cnt;
    logic              end_flag;
    logic [CMD_W-1:0]  sel_cmd;

    // Only the end flag belonging to the current busy state is allowed to release it.
    always_comb begin
        end_flag = 1'b0;
        case (state)
            S_AREF:  end_flag = flag_ref_end;
            S_WRITE: end_flag = flag_wr_end;
            S_READ:  end_flag = flag_rd_end;
            default: end_flag = 1'b0;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state    <= S_INIT;
            ref_en   <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            busy_err <= 1'b0;
            busy_cnt <= '0;
        end else begin
            ref_en <= 1'b0;
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
            case (state)
                S_INIT: begin
                    if (flag_init_end) state <= S_ARBIT;
                end
                S_ARBIT: begin
                    busy_cnt <= '0;
                    if (ref_req) begin
                        state  <= S_AREF;
                        ref_en <= 1'b1;
                    end else if (wr_req) begin
                        state <= S_WRITE;
                        wr_en <= 1'b1;
                    end else if (rd_req) begin
                        state <= S_READ;
                        rd_en <= 1'b1;
                    end
                end
                S_AREF, S_WRITE, S_READ: begin
                    if (end_flag) begin
                        state <= S_ARBIT;
                    end else if (busy_cnt == BUSY_LAST) begin
                        state    <= S_ARBIT;
                        busy_err <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Pins follow the state combinationally so a source's command lands in the cycle it is driven.
    always_comb begin
        sel_cmd    = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state)
            S_INIT: begin
                sel_cmd    = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sel_cmd    = aref_cmd;
                sdram_addr = ref_addr;
            end
            S_WRITE: begin
                sel_cmd    = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            S_READ: begin
                sel_cmd    = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                sel_cmd    = CMD_NOP;
                sdram_addr = '0;
                sdram_bank = '0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel_cmd;
    assign sdram_cke = 1'b1;

endmodule
